// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the data cache.
package dcache_pkg;

   localparam int unsigned LINE_W         = 256;
   localparam int unsigned OFFSET_W       = 5;
   localparam int unsigned INDEX_W        = 5;
   localparam int unsigned TAG_W          = 32 - INDEX_W - OFFSET_W;
   localparam int unsigned WORDS_PER_LINE = 8;
   localparam int unsigned WORD_SEL_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2
   } state_e;

   // Helpers return zero-extended fields so callers can size them to their own INDEX_W.
   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned index_w);
      return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned index_w);
      return addr >> (OFFSET_W + index_w);
   endfunction

   function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
      return addr[OFFSET_W-1:2];
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: combinational read, synchronous fill or word merge.
module dcache_sram #(
   parameter int unsigned INDEX_W = 5,
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned TAG_W   = 22
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [INDEX_W-1:0]                  index_i,
   input  logic [dcache_pkg::WORD_SEL_W-1:0]   word_sel_i,
   output logic [TAG_W-1:0]                    tag_o,
   output logic                                valid_o,
   output logic                                dirty_o,
   output logic [LINE_W-1:0]                   line_o,
   input  logic                                fill_en_i,
   input  logic [TAG_W-1:0]                    fill_tag_i,
   input  logic [LINE_W-1:0]                   fill_line_i,
   input  logic                                word_we_i,
   input  logic [31:0]                         word_data_i
);

   localparam int unsigned LINES = 1 << INDEX_W;
   localparam int unsigned WORDS = LINE_W / 32;

   logic [LINES-1:0]       valid_q, valid_d;
   logic [LINES-1:0]       dirty_q, dirty_d;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [WORDS-1:0][31:0] data_q [LINES];
   logic [WORDS-1:0][31:0] line_d;

   assign tag_o   = tag_q[index_i];
   assign valid_o = valid_q[index_i];
   assign dirty_o = dirty_q[index_i];
   assign line_o  = data_q[index_i];

   // A fill installs a clean line; a word merge on top of it marks the line dirty.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      line_d  = fill_en_i ? fill_line_i : data_q[index_i];
      if (fill_en_i) begin
         valid_d[index_i] = 1'b1;
         dirty_d[index_i] = 1'b0;
      end
      if (word_we_i) begin
         line_d[word_sel_i] = word_data_i;
         dirty_d[index_i]   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_en_i || word_we_i) begin
         data_q[index_i] <= line_d;
      end
      if (fill_en_i) begin
         tag_q[index_i] <= fill_tag_i;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache controller: hit logic, word mux,
// miss FSM and the registered memory request port.
module dcache_controller #(
   parameter int unsigned INDEX_W = dcache_pkg::INDEX_W,
   parameter int unsigned LINE_W  = dcache_pkg::LINE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic              p1_write_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   import dcache_pkg::OFFSET_W;
   import dcache_pkg::WORD_SEL_W;
   import dcache_pkg::state_e;
   import dcache_pkg::ST_IDLE;
   import dcache_pkg::ST_WRITEBACK;
   import dcache_pkg::ST_REFILL;
   import dcache_pkg::addr_index;
   import dcache_pkg::addr_tag;
   import dcache_pkg::addr_word;

   localparam int unsigned TAG_W = 32 - INDEX_W - OFFSET_W;
   localparam int unsigned WORDS = LINE_W / 32;

   logic [INDEX_W-1:0]     req_index;
   logic [TAG_W-1:0]       req_tag;
   logic [WORD_SEL_W-1:0]  word_sel;
   logic [31:0]            refill_addr;

   logic [TAG_W-1:0]       vic_tag;
   logic                   vic_valid;
   logic                   vic_dirty;
   logic [WORDS-1:0][31:0] vic_line;

   logic                   hit;
   logic                   fill_en;
   logic                   word_we;

   state_e                 state_q, state_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]      mem_data_q, mem_data_d;

   assign req_index   = INDEX_W'(addr_index(p1_addr_i, INDEX_W));
   assign req_tag     = TAG_W'(addr_tag(p1_addr_i, INDEX_W));
   assign word_sel    = addr_word(p1_addr_i);
   assign refill_addr = {req_tag, req_index, OFFSET_W'(0)};

   dcache_sram #(
      .INDEX_W (INDEX_W),
      .LINE_W  (LINE_W),
      .TAG_W   (TAG_W)
   ) u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .index_i     (req_index),
      .word_sel_i  (word_sel),
      .tag_o       (vic_tag),
      .valid_o     (vic_valid),
      .dirty_o     (vic_dirty),
      .line_o      (vic_line),
      .fill_en_i   (fill_en),
      .fill_tag_i  (req_tag),
      .fill_line_i (mem_data_i),
      .word_we_i   (word_we),
      .word_data_i (p1_data_i)
   );

   // Stall and load data are gated by reset so both drop the instant reset asserts.
   always_comb begin
      hit        = p1_req_i && vic_valid && (vic_tag == req_tag);
      p1_stall_o = rst_i && ((state_q != ST_IDLE) || (p1_req_i && !hit));
      p1_data_o  = (rst_i && hit) ? vic_line[word_sel] : 32'h0;
      word_we    = (state_q == ST_IDLE) && hit && p1_write_i;
   end

   always_comb begin
      state_d    = state_q;
      mem_en_d   = mem_en_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      fill_en    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (p1_req_i && !hit) begin
               mem_en_d = 1'b1;
               if (vic_valid && vic_dirty) begin
                  state_d    = ST_WRITEBACK;
                  mem_we_d   = 1'b1;
                  mem_addr_d = {vic_tag, req_index, OFFSET_W'(0)};
                  mem_data_d = vic_line;
               end else begin
                  state_d    = ST_REFILL;
                  mem_we_d   = 1'b0;
                  mem_addr_d = refill_addr;
                  mem_data_d = '0;
               end
            end
         end
         ST_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d    = ST_REFILL;
               mem_we_d   = 1'b0;
               mem_addr_d = refill_addr;
               mem_data_d = '0;
            end
         end
         ST_REFILL: begin
            if (mem_ack_i) begin
               fill_en    = 1'b1;
               state_d    = ST_IDLE;
               mem_en_d   = 1'b0;
               mem_addr_d = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign mem_enable_o = mem_en_q;
   assign mem_write_o  = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

endmodule
